// File: rtl/up_bus_tap_pkg.sv
// Shared types and record layout for the micro-processor bus tap.
// Record layout (LSB first): data[DW], 2'b00 + addr[AW-2], dir, optional timestamp[TS_W].
// Macro UP_BUS_TAP_TIMESTAMP_EN widens the record by TS_W bits at the top.
package up_bus_tap_pkg;

  localparam int TS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trig_state_e;

  localparam int REC_DATA_LSB = 0;

  function automatic int rec_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int rec_dir_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int rec_ts_lsb(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

  function automatic int rec_w(input int aw, input int dw);
`ifdef UP_BUS_TAP_TIMESTAMP_EN
    return TS_W + 1 + aw + dw;
`else
    return 1 + aw + dw;
`endif
  endfunction

endpackage

// File: rtl/up_bus_tap_win.sv
// Address window qualifier: hit in any inclusive window and in no exclusive window.
// Latency: combinational. Backpressure: none.
// Ports: addr (word address), incl/excl lo/hi flattened bound vectors, in_win result.
module up_bus_tap_win
  import up_bus_tap_pkg::*;
#(
  parameter int AW      = 16,
  parameter int NUM_WIN = 8
) (
  input  logic [AW-3:0]             addr,
  input  logic [NUM_WIN*(AW-2)-1:0] incl_lo,
  input  logic [NUM_WIN*(AW-2)-1:0] incl_hi,
  input  logic [NUM_WIN*(AW-2)-1:0] excl_lo,
  input  logic [NUM_WIN*(AW-2)-1:0] excl_hi,
  output logic                      in_win
);

  localparam int WA = AW - 2;

  logic incl_hit;
  logic excl_hit;

  // A window with lo > hi can never satisfy both bounds, so it is empty.
  always_comb begin
    incl_hit = 1'b0;
    excl_hit = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if ((incl_lo[i*WA +: WA] <= addr) && (addr <= incl_hi[i*WA +: WA]))
        incl_hit = 1'b1;
      if ((excl_lo[i*WA +: WA] <= addr) && (addr <= excl_hi[i*WA +: WA]))
        excl_hit = 1'b1;
    end
    in_win = incl_hit & ~excl_hit;
  end

endmodule

// File: rtl/up_bus_tap.sv
// Passive tap on a uP bus: captures windowed accesses, optional address/data trigger with post count.
// Latency: record valid the cycle after the strobe-derived event (3 edges after strobe asserts).
// Backpressure: one-entry holding register; a new record while full and not accepted is dropped and counted.
// Ports: up_* bus inputs, incl/excl window bounds, trig_* trigger config, cap_valid/cap_ready/cap_data
// record stream, trig_state FSM state, drop_cnt saturating drop counter.
// Macro UP_BUS_TAP_TIMESTAMP_EN: prepend a free-running 16-bit cycle stamp to each record.
module up_bus_tap
  import up_bus_tap_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int NUM_WIN = 8,
  parameter int PCNT_W  = 9
) (
  input  logic                      up_clk,
  input  logic                      up_rstn,
  input  logic                      up_csn,
  input  logic                      up_wbe,
  input  logic                      up_rbe,
  input  logic [AW-1:2]             up_addr,
  input  logic [DW-1:0]             up_data_io,
  input  logic [NUM_WIN*(AW-2)-1:0] incl_lo,
  input  logic [NUM_WIN*(AW-2)-1:0] incl_hi,
  input  logic [NUM_WIN*(AW-2)-1:0] excl_lo,
  input  logic [NUM_WIN*(AW-2)-1:0] excl_hi,
  input  logic                      trig_en,
  input  logic                      trig_arm,
  input  logic                      trig_dir,
  input  logic [AW-1:2]             trig_addr,
  input  logic [DW-1:0]             trig_data,
  input  logic [DW-1:0]             trig_dmask,
  input  logic [PCNT_W-1:0]         post_cnt,
  output logic                      cap_valid,
  input  logic                      cap_ready,
  output logic [rec_w(AW,DW)-1:0]   cap_data,
  output logic [1:0]                trig_state,
  output logic [15:0]               drop_cnt
);

  localparam int REC_W    = rec_w(AW, DW);
  localparam int ADDR_LSB = rec_addr_lsb(DW);
  localparam int DIR_BIT  = rec_dir_bit(AW, DW);

  // Strobe history; the event fires one cycle after the active level has
  // been seen twice, giving the bus time to settle before sampling.
  logic d1, d2, d3;
  logic strb_n;
  logic evt;

  assign strb_n = up_csn | (up_wbe & up_rbe);
  assign evt    = ~d2 & d3;

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      d1 <= 1'b1;
      d2 <= 1'b1;
      d3 <= 1'b1;
    end else begin
      d1 <= strb_n;
      d2 <= d1;
      d3 <= d2;
    end
  end

  logic in_win;

  up_bus_tap_win #(
    .AW      (AW),
    .NUM_WIN (NUM_WIN)
  ) u_win (
    .addr    (up_addr),
    .incl_lo (incl_lo),
    .incl_hi (incl_hi),
    .excl_lo (excl_lo),
    .excl_hi (excl_hi),
    .in_win  (in_win)
  );

  logic dir;
  logic match;

  assign dir   = ~up_wbe;
  assign match = in_win && (dir == trig_dir) && (up_addr == trig_addr) &&
                 (((up_data_io ^ trig_data) & trig_dmask) == '0);

  trig_state_e       state;
  logic [PCNT_W-1:0] cnt;
  logic              qual;

  assign trig_state = state;

  always_comb begin
    qual = 1'b0;
    case (state)
      ST_IDLE:  qual = evt & in_win & ~trig_en;
      ST_ARMED: qual = evt & match;
      ST_POST:  qual = evt & in_win;
      default:  qual = 1'b0;
    endcase
  end

`ifdef UP_BUS_TAP_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) ts <= '0;
    else          ts <= ts + TS_W'(1);
  end
`endif

  logic [REC_W-1:0] rec;

  always_comb begin
    rec = '0;
    rec[REC_DATA_LSB +: DW] = up_data_io;
    rec[ADDR_LSB +: AW]     = {up_addr, 2'b00};
    rec[DIR_BIT]            = dir;
`ifdef UP_BUS_TAP_TIMESTAMP_EN
    rec[rec_ts_lsb(AW, DW) +: TS_W] = ts;
`endif
  end

  // Trigger FSM. trig_en low overrides everything, including an arm pulse.
  // In POST every in-window event consumes a count whether or not it was
  // accepted downstream, so the capture window is fixed in bus time.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (!trig_en) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (trig_arm) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (evt && match) begin
            cnt   <= post_cnt;
            state <= (post_cnt == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (evt && in_win) begin
            cnt <= (cnt == '0) ? '0 : cnt - PCNT_W'(1);
            if (cnt <= PCNT_W'(1)) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single holding register; a handshake in the same cycle frees the slot
  // for the incoming record, so that case is not a drop.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
      drop_cnt  <= '0;
    end else if (qual) begin
      if (!cap_valid || cap_ready) begin
        cap_valid <= 1'b1;
        cap_data  <= rec;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (cap_ready) begin
      cap_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_up_bus_tap.sv
// Directed bench for up_bus_tap: windowed capture, backpressure/drop, trigger FSM, reset.
`timescale 1ns/1ps
module tb_up_bus_tap;
  import up_bus_tap_pkg::*;

  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int NUM_WIN = 8;
  localparam int PCNT_W  = 9;
  localparam int WA      = AW - 2;
  localparam int REC_W   = rec_w(AW, DW);

  logic                    up_clk = 1'b0;
  logic                    up_rstn;
  logic                    up_csn, up_wbe, up_rbe;
  logic [WA-1:0]           up_addr;
  logic [DW-1:0]           up_data_io;
  logic [NUM_WIN*WA-1:0]   incl_lo, incl_hi, excl_lo, excl_hi;
  logic                    trig_en, trig_arm, trig_dir;
  logic [WA-1:0]           trig_addr;
  logic [DW-1:0]           trig_data, trig_dmask;
  logic [PCNT_W-1:0]       post_cnt;
  logic                    cap_valid, cap_ready;
  logic [REC_W-1:0]        cap_data;
  logic [1:0]              trig_state;
  logic [15:0]             drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 up_clk = ~up_clk;

  up_bus_tap #(
    .AW(AW), .DW(DW), .NUM_WIN(NUM_WIN), .PCNT_W(PCNT_W)
  ) dut (
    .up_clk(up_clk), .up_rstn(up_rstn), .up_csn(up_csn), .up_wbe(up_wbe),
    .up_rbe(up_rbe), .up_addr(up_addr), .up_data_io(up_data_io),
    .incl_lo(incl_lo), .incl_hi(incl_hi), .excl_lo(excl_lo), .excl_hi(excl_hi),
    .trig_en(trig_en), .trig_arm(trig_arm), .trig_dir(trig_dir),
    .trig_addr(trig_addr), .trig_data(trig_data), .trig_dmask(trig_dmask),
    .post_cnt(post_cnt), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_data(cap_data), .trig_state(trig_state), .drop_cnt(drop_cnt)
  );

  function automatic logic [AW+DW:0] rec(input logic d, input logic [WA-1:0] a,
                                         input logic [DW-1:0] v);
    return {d, a, 2'b00, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input logic wr, input logic [WA-1:0] a, input logic [DW-1:0] v);
    @(negedge up_clk);
    up_csn = 1'b0; up_wbe = ~wr; up_rbe = wr; up_addr = a; up_data_io = v;
    repeat (4) @(negedge up_clk);
    up_csn = 1'b1; up_wbe = 1'b1; up_rbe = 1'b1;
    repeat (2) @(negedge up_clk);
  endtask

  task automatic pop(input string tag);
    @(negedge up_clk); cap_ready = 1'b1;
    @(negedge up_clk); cap_ready = 1'b0;
    chk({tag, "_pop"}, {63'd0, cap_valid}, 64'd0);
  endtask

  task automatic expect_rec(input string tag, input logic [AW+DW:0] exp);
    chk({tag, "_vld"}, {63'd0, cap_valid}, 64'd1);
    chk({tag, "_dat"}, {15'd0, cap_data[AW+DW:0]}, {15'd0, exp});
    pop(tag);
  endtask

  task automatic expect_none(input string tag);
    chk({tag, "_none"}, {63'd0, cap_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    up_rstn = 1'b0; up_csn = 1'b1; up_wbe = 1'b1; up_rbe = 1'b1;
    up_addr = '0; up_data_io = '0; cap_ready = 1'b0;
    trig_en = 1'b0; trig_arm = 1'b0; trig_dir = 1'b0; trig_addr = '0;
    trig_data = '0; trig_dmask = '0; post_cnt = '0;
    incl_lo = {NUM_WIN{14'h3FFF}}; incl_hi = '0;
    excl_lo = {NUM_WIN{14'h3FFF}}; excl_hi = '0;
    incl_lo[0 +: WA] = 14'h10; incl_hi[0 +: WA] = 14'h20;

    // Reset state
    repeat (2) @(negedge up_clk);
    chk("rst_vld",   {63'd0, cap_valid}, 64'd0);
    chk("rst_dat",   {15'd0, cap_data[AW+DW:0]}, 64'd0);
    chk("rst_drop",  {48'd0, drop_cnt}, 64'd0);
    chk("rst_state", {62'd0, trig_state}, 64'd0);
    up_rstn = 1'b1;
    repeat (2) @(negedge up_clk);

    // Basic write capture with latency check
    @(negedge up_clk);
    up_csn = 1'b0; up_wbe = 1'b0; up_addr = 14'h14; up_data_io = 32'hDEADBEEF;
    repeat (2) @(negedge up_clk);
    chk("lat_early", {63'd0, cap_valid}, 64'd0);
    @(negedge up_clk);
    chk("lat_vld", {63'd0, cap_valid}, 64'd1);
    chk("lat_dat", {15'd0, cap_data[AW+DW:0]}, {15'd0, rec(1'b1, 14'h14, 32'hDEADBEEF)});
    @(negedge up_clk);
    up_csn = 1'b1; up_wbe = 1'b1;
    repeat (2) @(negedge up_clk);
    pop("lat");

    // Read at upper bound, then just outside both ends
    bus_op(1'b0, 14'h20, 32'h00001234);
    expect_rec("rd_hi", rec(1'b0, 14'h20, 32'h00001234));
    bus_op(1'b0, 14'h21, 32'h1);
    expect_none("rd_out_hi");
    bus_op(1'b1, 14'h0F, 32'h2);
    expect_none("wr_out_lo");

    // Exclusive window carves out 0x14
    excl_lo[0 +: WA] = 14'h14; excl_hi[0 +: WA] = 14'h14;
    bus_op(1'b1, 14'h14, 32'h3);
    expect_none("excl_14");
    bus_op(1'b1, 14'h15, 32'hCAFE0015);
    expect_rec("excl_15", rec(1'b1, 14'h15, 32'hCAFE0015));

    // Backpressure: first held, two dropped
    bus_op(1'b1, 14'h11, 32'hA1);
    bus_op(1'b1, 14'h12, 32'hA2);
    bus_op(1'b1, 14'h13, 32'hA3);
    chk("bp_vld",  {63'd0, cap_valid}, 64'd1);
    chk("bp_dat",  {15'd0, cap_data[AW+DW:0]}, {15'd0, rec(1'b1, 14'h11, 32'hA1)});
    chk("bp_drop", {48'd0, drop_cnt}, 64'd2);

    // Handshake coincides with the event edge: replace, no drop
    @(negedge up_clk);
    up_csn = 1'b0; up_wbe = 1'b0; up_addr = 14'h16; up_data_io = 32'hB6;
    repeat (2) @(negedge up_clk);
    cap_ready = 1'b1;
    @(negedge up_clk);
    cap_ready = 1'b0;
    chk("co_vld",  {63'd0, cap_valid}, 64'd1);
    chk("co_dat",  {15'd0, cap_data[AW+DW:0]}, {15'd0, rec(1'b1, 14'h16, 32'hB6)});
    chk("co_drop", {48'd0, drop_cnt}, 64'd2);
    @(negedge up_clk);
    up_csn = 1'b1; up_wbe = 1'b1;
    repeat (2) @(negedge up_clk);
    pop("co");

    // Trigger: enable, arm, match 0x18 low byte 0x5A, two post records
    @(negedge up_clk);
    trig_en = 1'b1; trig_dir = 1'b1; trig_addr = 14'h18;
    trig_data = 32'h5A; trig_dmask = 32'hFF; post_cnt = 9'd2;
    @(negedge up_clk);
    chk("tr_idle", {62'd0, trig_state}, 64'd0);
    bus_op(1'b1, 14'h11, 32'h0);
    expect_none("tr_idle_en");
    trig_arm = 1'b1;
    @(negedge up_clk);
    trig_arm = 1'b0;
    chk("tr_armed", {62'd0, trig_state}, 64'd1);
    bus_op(1'b1, 14'h10, 32'h5A);
    expect_none("tr_addr_miss");
    bus_op(1'b1, 14'h18, 32'h00000000);
    expect_none("tr_data_miss");
    bus_op(1'b0, 14'h18, 32'h5A);
    expect_none("tr_dir_miss");
    chk("tr_still_armed", {62'd0, trig_state}, 64'd1);
    bus_op(1'b1, 14'h18, 32'h125A);
    chk("tr_post", {62'd0, trig_state}, 64'd2);
    expect_rec("tr_match", rec(1'b1, 14'h18, 32'h125A));
    bus_op(1'b1, 14'h11, 32'h11);
    chk("tr_post1", {62'd0, trig_state}, 64'd2);
    expect_rec("tr_p1", rec(1'b1, 14'h11, 32'h11));
    bus_op(1'b1, 14'h12, 32'h12);
    chk("tr_done", {62'd0, trig_state}, 64'd3);
    expect_rec("tr_p2", rec(1'b1, 14'h12, 32'h12));
    bus_op(1'b1, 14'h13, 32'h13);
    expect_none("tr_after_done");
    chk("tr_done2", {62'd0, trig_state}, 64'd3);

    // Re-arm from DONE, match, then drop trig_en while in POST
    trig_arm = 1'b1;
    @(negedge up_clk);
    trig_arm = 1'b0;
    chk("re_armed", {62'd0, trig_state}, 64'd1);
    bus_op(1'b1, 14'h18, 32'hAB5A);
    chk("re_post", {62'd0, trig_state}, 64'd2);
    trig_en = 1'b0;
    @(negedge up_clk);
    chk("en_off_idle", {62'd0, trig_state}, 64'd0);

    // post_cnt = 0: match goes straight to DONE; slot full so it is dropped
    trig_en = 1'b1; post_cnt = 9'd0; trig_arm = 1'b1;
    @(negedge up_clk);
    trig_arm = 1'b0;
    chk("z_armed", {62'd0, trig_state}, 64'd1);
    bus_op(1'b1, 14'h18, 32'h5A);
    chk("z_done", {62'd0, trig_state}, 64'd3);
    chk("z_drop", {48'd0, drop_cnt}, 64'd3);
    chk("z_held", {15'd0, cap_data[AW+DW:0]}, {15'd0, rec(1'b1, 14'h18, 32'hAB5A)});

    // trig_en low wins over a simultaneous arm
    trig_en = 1'b0; trig_arm = 1'b1;
    @(negedge up_clk);
    trig_arm = 1'b0;
    chk("prio_idle", {62'd0, trig_state}, 64'd0);

    // Reset while a record is held
    chk("pre_rst_vld", {63'd0, cap_valid}, 64'd1);
    up_rstn = 1'b0;
    #1;
    chk("mid_rst_vld",  {63'd0, cap_valid}, 64'd0);
    chk("mid_rst_drop", {48'd0, drop_cnt}, 64'd0);
    chk("mid_rst_dat",  {15'd0, cap_data[AW+DW:0]}, 64'd0);
    @(negedge up_clk);
    up_rstn = 1'b1;
    repeat (2) @(negedge up_clk);
    bus_op(1'b1, 14'h1F, 32'h0F0F0F0F);
    expect_rec("post_rst", rec(1'b1, 14'h1F, 32'h0F0F0F0F));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
